// File: rtl/mod_n_count_checker_if.sv
// ---------------------------------------------------------------------------
// mod_n_count_checker_if
//
// Bundles the sample stream and the status readout of the mod-N count checker.
//   master : count producer / status consumer (drives en, count_in, clr_stats)
//   slave  : the checker itself (drives locked, pulses, counters, exp_count)
//
// Signals
//   en          sample qualifier
//   count_in    monitored count value (WIDTH)
//   clr_stats   synchronous clear of both statistics counters
//   locked      checker is tracking the stream
//   err_pulse   one-cycle pulse per detected error
//   wrap_pulse  one-cycle pulse per good N-1 -> 0 transition while locked
//   err_cnt     saturating error count (ERR_W)
//   wrap_cnt    saturating wrap count (WRAP_W)
//   exp_count   value expected on the next qualified sample (WIDTH)
// ---------------------------------------------------------------------------
interface mod_n_count_checker_if #(
    parameter int WIDTH  = 4,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 16
);
    logic              en;
    logic [WIDTH-1:0]  count_in;
    logic              clr_stats;
    logic              locked;
    logic              err_pulse;
    logic              wrap_pulse;
    logic [ERR_W-1:0]  err_cnt;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [WIDTH-1:0]  exp_count;

    modport master (
        output en, count_in, clr_stats,
        input  locked, err_pulse, wrap_pulse, err_cnt, wrap_cnt, exp_count
    );

    modport slave (
        input  en, count_in, clr_stats,
        output locked, err_pulse, wrap_pulse, err_cnt, wrap_cnt, exp_count
    );
endinterface

// File: rtl/mod_n_count_checker.sv
// ---------------------------------------------------------------------------
// mod_n_count_checker
//
// Receive-side monitor for a mod-N counter bus. Acquires lock after LOCK_CNT
// consecutive legal increments, then flags sequence breaks and out-of-range
// values, and counts wraps and errors (both saturating).
//
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous reset, active low
//   bus   mod_n_count_checker_if.slave (see interface header for signals)
//
// All status outputs are registered and reflect the sample taken at the
// previous rising edge.
// ---------------------------------------------------------------------------
module mod_n_count_checker #(
    parameter int N        = 10,
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    mod_n_count_checker_if.slave        bus
);

    localparam int GR_W = $clog2(LOCK_CNT + 1);

    localparam logic [WIDTH-1:0] LAST      = WIDTH'(N - 1);
    localparam logic [WIDTH:0]   N_W       = (WIDTH + 1)'(N);
    localparam logic [GR_W-1:0]  LOCK_LAST = GR_W'(LOCK_CNT - 1);

    generate
        if (N < 2 || N > 2**WIDTH || LOCK_CNT < 1) begin : g_bad_params
            $error("mod_n_count_checker: illegal N / WIDTH / LOCK_CNT combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  prev_reg;
    logic [GR_W-1:0]   good_run_reg;
    logic              locked_reg;
    logic              err_pulse_reg;
    logic              wrap_pulse_reg;
    logic [ERR_W-1:0]  err_cnt_reg;
    logic [WRAP_W-1:0] wrap_cnt_reg;
    logic [WIDTH-1:0]  exp_count_reg;

    logic in_range;
    logic match;
    logic err_event;
    logic wrap_event;

    function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] v);
        return (v == LAST) ? '0 : v + 1'b1;
    endfunction

    // With a full-range modulus every bus value is legal, so the range
    // comparator disappears entirely.
    generate
        if (N == 2**WIDTH) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            assign in_range = ({1'b0, bus.count_in} < N_W);
        end
    endgenerate

    // An out-of-range value can never equal succ(prev), so a mismatch alone
    // covers both sequence and range errors; in_range is kept explicit here
    // for readability.
    always_comb begin
        match      = (bus.count_in == succ(prev_reg));
        err_event  = bus.en && (state_reg == ST_LOCKED) && !(in_range && match);
        wrap_event = bus.en && (state_reg == ST_LOCKED) && in_range && match
                     && (prev_reg == LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            prev_reg       <= '0;
            good_run_reg   <= '0;
            locked_reg     <= 1'b0;
            err_pulse_reg  <= 1'b0;
            wrap_pulse_reg <= 1'b0;
            err_cnt_reg    <= '0;
            wrap_cnt_reg   <= '0;
            exp_count_reg  <= '0;
        end else begin
            err_pulse_reg  <= 1'b0;
            wrap_pulse_reg <= 1'b0;

            if (bus.en) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (in_range) begin
                            state_reg     <= ST_ACQUIRE;
                            prev_reg      <= bus.count_in;
                            good_run_reg  <= '0;
                            exp_count_reg <= succ(bus.count_in);
                        end
                    end

                    ST_ACQUIRE: begin
                        if (!in_range) begin
                            state_reg     <= ST_IDLE;
                            good_run_reg  <= '0;
                            exp_count_reg <= '0;
                        end else begin
                            prev_reg      <= bus.count_in;
                            exp_count_reg <= succ(bus.count_in);
                            if (match) begin
                                if (good_run_reg == LOCK_LAST) begin
                                    state_reg  <= ST_LOCKED;
                                    locked_reg <= 1'b1;
                                end
                                good_run_reg <= good_run_reg + 1'b1;
                            end else begin
                                // Mismatch while acquiring just restarts the run.
                                good_run_reg <= '0;
                            end
                        end
                    end

                    ST_LOCKED: begin
                        if (!in_range) begin
                            state_reg     <= ST_IDLE;
                            locked_reg    <= 1'b0;
                            err_pulse_reg <= 1'b1;
                            good_run_reg  <= '0;
                            exp_count_reg <= '0;
                        end else if (match) begin
                            prev_reg       <= bus.count_in;
                            exp_count_reg  <= succ(bus.count_in);
                            wrap_pulse_reg <= (prev_reg == LAST);
                        end else begin
                            state_reg     <= ST_ACQUIRE;
                            locked_reg    <= 1'b0;
                            err_pulse_reg <= 1'b1;
                            prev_reg      <= bus.count_in;
                            good_run_reg  <= '0;
                            exp_count_reg <= succ(bus.count_in);
                        end
                    end

                    default: begin
                        state_reg     <= ST_IDLE;
                        locked_reg    <= 1'b0;
                        good_run_reg  <= '0;
                        exp_count_reg <= '0;
                    end
                endcase
            end

            // Clear has priority over a same-cycle increment; pulses above
            // are unaffected by it.
            if (bus.clr_stats) begin
                err_cnt_reg <= '0;
            end else if (err_event && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end

            if (bus.clr_stats) begin
                wrap_cnt_reg <= '0;
            end else if (wrap_event && (wrap_cnt_reg != '1)) begin
                wrap_cnt_reg <= wrap_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.locked     = locked_reg;
    assign bus.err_pulse  = err_pulse_reg;
    assign bus.wrap_pulse = wrap_pulse_reg;
    assign bus.err_cnt    = err_cnt_reg;
    assign bus.wrap_cnt   = wrap_cnt_reg;
    assign bus.exp_count  = exp_count_reg;

endmodule

// File: tb/tb_mod_n_count_checker.sv
// ---------------------------------------------------------------------------
// tb_mod_n_count_checker
//
// Two checker instances share one stimulus stream:
//   i0 : N=10, WIDTH=4, LOCK_CNT=2, ERR_W=2 (error saturation), WRAP_W=16
//   i1 : N=16, WIDTH=4, LOCK_CNT=3, ERR_W=8, WRAP_W=2 (full range, wrap sat.)
// A behavioural model per instance predicts all outputs after every edge.
// ---------------------------------------------------------------------------
module tb_mod_n_count_checker;

    logic clk;
    logic rst_n;

    mod_n_count_checker_if #(.WIDTH(4), .ERR_W(2), .WRAP_W(16)) bus0 ();
    mod_n_count_checker_if #(.WIDTH(4), .ERR_W(8), .WRAP_W(2))  bus1 ();

    mod_n_count_checker #(.N(10), .WIDTH(4), .LOCK_CNT(2), .ERR_W(2), .WRAP_W(16)) dut0 (
        .clk (clk),
        .rst (rst_n),
        .bus (bus0.slave)
    );

    mod_n_count_checker #(.N(16), .WIDTH(4), .LOCK_CNT(3), .ERR_W(8), .WRAP_W(2)) dut1 (
        .clk (clk),
        .rst (rst_n),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Per-instance model configuration.
    int NN      [2] = '{10, 16};
    int LK      [2] = '{2, 3};
    int ERR_MAX [2] = '{3, 255};
    int WRAP_MAX[2] = '{65535, 3};

    // Model state: mode 0 = no reference value, 1 = acquiring, 2 = tracking.
    int m_mode[2];
    int m_prev[2];
    int m_run [2];
    int m_err [2];
    int m_wrap[2];
    int m_exp [2];
    bit m_ep  [2];
    bit m_wp  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset(input int k);
        m_mode[k] = 0;
        m_prev[k] = 0;
        m_run[k]  = 0;
        m_err[k]  = 0;
        m_wrap[k] = 0;
        m_exp[k]  = 0;
        m_ep[k]   = 1'b0;
        m_wp[k]   = 1'b0;
    endfunction

    function automatic void model_step(input int k, input bit e, input int v, input bit c);
        bit inr;
        bit hit;
        m_ep[k] = 1'b0;
        m_wp[k] = 1'b0;
        if (e) begin
            inr = (v < NN[k]);
            hit = inr && (v == (m_prev[k] + 1) % NN[k]);
            case (m_mode[k])
                0: begin
                    if (inr) begin
                        m_prev[k] = v;
                        m_run[k]  = 0;
                        m_mode[k] = 1;
                    end
                end
                1: begin
                    if (!inr) begin
                        m_mode[k] = 0;
                    end else begin
                        if (hit) begin
                            m_run[k]++;
                            if (m_run[k] >= LK[k]) m_mode[k] = 2;
                        end else begin
                            m_run[k] = 0;
                        end
                        m_prev[k] = v;
                    end
                end
                default: begin
                    if (hit) begin
                        if (m_prev[k] == NN[k] - 1) m_wp[k] = 1'b1;
                        m_prev[k] = v;
                    end else begin
                        m_ep[k] = 1'b1;
                        if (inr) begin
                            m_prev[k] = v;
                            m_run[k]  = 0;
                            m_mode[k] = 1;
                        end else begin
                            m_mode[k] = 0;
                        end
                    end
                end
            endcase
        end
        if (c) begin
            m_err[k]  = 0;
            m_wrap[k] = 0;
        end else begin
            if (m_ep[k] && m_err[k] < ERR_MAX[k])   m_err[k]++;
            if (m_wp[k] && m_wrap[k] < WRAP_MAX[k]) m_wrap[k]++;
        end
        m_exp[k] = (m_mode[k] == 0) ? 0 : (m_prev[k] + 1) % NN[k];
    endfunction

    task automatic check_all(input string ph);
        chk({ph, " i0.locked"},     32'(bus0.locked),     32'(m_mode[0] == 2));
        chk({ph, " i0.err_pulse"},  32'(bus0.err_pulse),  32'(m_ep[0]));
        chk({ph, " i0.wrap_pulse"}, 32'(bus0.wrap_pulse), 32'(m_wp[0]));
        chk({ph, " i0.err_cnt"},    32'(bus0.err_cnt),    32'(m_err[0]));
        chk({ph, " i0.wrap_cnt"},   32'(bus0.wrap_cnt),   32'(m_wrap[0]));
        chk({ph, " i0.exp_count"},  32'(bus0.exp_count),  32'(m_exp[0]));
        chk({ph, " i1.locked"},     32'(bus1.locked),     32'(m_mode[1] == 2));
        chk({ph, " i1.err_pulse"},  32'(bus1.err_pulse),  32'(m_ep[1]));
        chk({ph, " i1.wrap_pulse"}, 32'(bus1.wrap_pulse), 32'(m_wp[1]));
        chk({ph, " i1.err_cnt"},    32'(bus1.err_cnt),    32'(m_err[1]));
        chk({ph, " i1.wrap_cnt"},   32'(bus1.wrap_cnt),   32'(m_wrap[1]));
        chk({ph, " i1.exp_count"},  32'(bus1.exp_count),  32'(m_exp[1]));
    endtask

    // One qualified-or-idle clock: drive, step the model at the edge, then
    // sample outputs 1 time unit after the edge.
    task automatic cycle(input bit e, input int v, input bit c, input string ph);
        bus0.en        = e;
        bus0.count_in  = 4'(v);
        bus0.clr_stats = c;
        bus1.en        = e;
        bus1.count_in  = 4'(v);
        bus1.clr_stats = c;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) model_reset(k);
            else        model_step(k, e, v, c);
        end
        #1;
        $display("%s en=%0d cin=%0d clr=%0d | i0 L=%0d E=%0d W=%0d ec=%0d wc=%0d x=%0d | i1 L=%0d E=%0d W=%0d ec=%0d wc=%0d x=%0d",
                 ph, e, v, c,
                 bus0.locked, bus0.err_pulse, bus0.wrap_pulse, bus0.err_cnt, bus0.wrap_cnt, bus0.exp_count,
                 bus1.locked, bus1.err_pulse, bus1.wrap_pulse, bus1.err_cnt, bus1.wrap_cnt, bus1.exp_count);
        check_all(ph);
    endtask

    // Asserts reset between edges, checks the outputs cleared without any
    // edge, holds reset for a couple of qualified cycles, then releases.
    task automatic async_reset(input string ph);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_all({ph, " async"});
        repeat (2) cycle(1'b1, int'($urandom_range(15)), 1'b0, {ph, " in_rst"});
        rst_n = 1'b1;
    endtask

    task automatic feed(input int from, input int to, input string ph);
        for (int v = from; v <= to; v++) cycle(1'b1, v, 1'b0, ph);
    endtask

    task automatic rand_phase(input int ncyc, input int md, input string ph);
        int  last;
        int  r;
        int  v;
        bit  e;
        bit  c;
        last = 0;
        for (int i = 0; i < ncyc; i++) begin
            e = ($urandom_range(99) < 80);
            c = ($urandom_range(99) < 2);
            r = int'($urandom_range(99));
            if (r < 80)      v = (last + 1) % md;
            else if (r < 88) v = int'($urandom_range(md - 1));
            else             v = int'($urandom_range(15));
            if (e && v < md) last = v;
            cycle(e, v, c, ph);
            if ($urandom_range(399) == 0) async_reset(ph);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus0.en        = 1'b1;
        bus0.count_in  = 4'd5;
        bus0.clr_stats = 1'b0;
        bus1.en        = 1'b1;
        bus1.count_in  = 4'd5;
        bus1.clr_stats = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check_all("reset");
        repeat (3) cycle(1'b1, int'($urandom_range(15)), 1'b0, "reset");
        rst_n = 1'b1;
        repeat (3) cycle(1'b0, int'($urandom_range(15)), 1'b0, "idle");

        // Acquire on 0,1,2.
        feed(0, 2, "acquire");

        // Run through a wrap with 3-cycle en=0 gaps.
        feed(3, 5, "wrap");
        repeat (3) cycle(1'b0, int'($urandom_range(15)), 1'b0, "gap");
        feed(6, 9, "wrap");
        repeat (3) cycle(1'b0, int'($urandom_range(15)), 1'b0, "gap");
        feed(0, 1, "wrap");

        // Sequence error at 4 -> 7, then relock with 8,9.
        feed(2, 4, "seq");
        cycle(1'b1, 7, 1'b0, "seq_err");
        feed(8, 9, "relock");

        // Range error while locked.
        cycle(1'b1, 0, 1'b0, "range");
        cycle(1'b1, 12, 1'b0, "range_err");

        // Force enough errors to saturate the 2-bit error counter.
        for (int i = 0; i < 5; i++) begin
            feed(0, 2, "sat_lock");
            cycle(1'b1, 12, 1'b0, "sat_err");
        end

        // Clear on the same cycle as an error.
        feed(0, 2, "clr_lock");
        cycle(1'b1, 15, 1'b1, "clr_err");

        // Lock both instances, then reset between edges.
        feed(0, 5, "pre_rst");
        async_reset("mid_rst");
        repeat (2) cycle(1'b0, 3, 1'b0, "post_rst");

        rand_phase(1200, 10, "rand10");
        rand_phase(800, 16, "rand16");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_n_count_checker.md
Name: mod_n_count_checker

Overview:
Receive-side monitor for the mod-N counter output bus. It samples a count stream, acquires lock on a legal mod-N increment sequence, and flags sequence or range errors. It also counts wrap events and errors for debug and status readout. It sits downstream of any mod-N counter instance, on the consumer side of its count bus.

Parameters:
N, 10, counter modulus; legal values are 0..N-1; N >= 2 and N <= 2**WIDTH (elaboration check)
WIDTH, 4, width of the count bus
LOCK_CNT, 2, consecutive good transitions needed to declare lock; >= 1
ERR_W, 8, width of the error counter
WRAP_W, 16, width of the wrap counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
en  input  1  sample qualifier; count_in is consumed only when en=1
count_in  input  WIDTH  count value from the monitored counter
clr_stats  input  1  synchronous clear of err_cnt and wrap_cnt
locked  output  1  registered; 1 while the stream is tracked
err_pulse  output  1  one-cycle pulse per detected error
wrap_pulse  output  1  one-cycle pulse per good (N-1 -> 0) transition while locked
err_cnt  output  ERR_W  saturating count of errors
wrap_cnt  output  WRAP_W  saturating count of wraps
exp_count  output  WIDTH  value expected on the next qualified sample; 0 when no previous sample exists

Behaviour:
- Reset (rst=0, async): state IDLE, prev=0, good_run=0, all outputs 0. Reset mid-operation discards lock and stats immediately.
- Successor rule: succ(v) = 0 if v == N-1, else v+1. exp_count = succ(prev) in ACQUIRE and LOCKED.
- Sample qualification: a sample is in-range if count_in < N.
- en=0: no state change, pulses 0, counters hold. Gaps of any length do not break lock.
- FSM, evaluated only on cycles with en=1:
  - IDLE:
    - in-range: prev=count_in, good_run=0, go to ACQUIRE.
    - out-of-range: stay in IDLE, no error.
  - ACQUIRE:
    - in-range and == succ(prev): good_run+1. If good_run reaches LOCK_CNT, go to LOCKED.
    - in-range mismatch: prev=count_in, good_run=0, stay in ACQUIRE, no error.
    - out-of-range: go to IDLE.
    - prev is updated with every in-range sample.
  - LOCKED:
    - match: stay in LOCKED. If prev == N-1, assert wrap_pulse and increment wrap_cnt.
    - in-range mismatch: assert err_pulse, increment err_cnt, prev=count_in, good_run=0, go to ACQUIRE.
    - out-of-range: assert err_pulse, increment err_cnt, go to IDLE.
- Latency: locked, err_pulse, wrap_pulse, counters and exp_count update at the clock edge that samples the triggering count_in. They are visible in the following cycle, one cycle of latency.
- locked = (state == LOCKED), registered.
- Counters saturate at all-ones and never wrap.
- clr_stats=1: both counters become 0 at that edge. Clear wins over a simultaneous increment. Pulses are still asserted normally.
- Errors are never counted outside LOCKED.
- N == 2**WIDTH: out-of-range is impossible and that logic is constant-folded.

Test Plan:
1. Reset: hold rst=0 with arbitrary count_in and en=1 -> locked=0, err_pulse=0, wrap_pulse=0, err_cnt=0, wrap_cnt=0, exp_count=0. Release rst -> outputs stay 0 until samples arrive.
2. Acquire (N=10, LOCK_CNT=2): feed 0,1,2 with en=1 on consecutive cycles -> exp_count=1 then 2. locked=1 in the cycle after sample 2 is taken. err_cnt=0.
3. Wrap: after lock, feed 3..9,0,1 -> wrap_pulse high for exactly one cycle, after the 0 following 9. wrap_cnt=1. err_pulse never asserted. Insert en=0 gaps of 3 cycles -> locked stays 1 and results are unchanged.
4. Sequence error: locked at 4, feed 7 -> err_pulse for one cycle, err_cnt=1, locked=0, exp_count=8. Feed 8,9 -> locked=1 again, err_cnt still 1.
5. Range error and saturation: while locked, feed 12 -> err_pulse, err_cnt+1, state IDLE, locked=0, exp_count=0. With ERR_W=2, force 5 errors -> err_cnt stays 3.
6. Clear and async reset: assert clr_stats on the same cycle as an error -> err_cnt=0 and err_pulse=1. Drop rst mid-cycle while locked -> locked=0 immediately (asynchronous), without waiting for a clock edge.
